// File: rtl/menshen_defs.sv
// Shared definitions for the egress path: PHV geometry, the queue-field location
// and the occupancy-derived FIFO state.
package menshen_defs;

  localparam int PHV_LEN       = 48*8 + 32*8 + 16*8 + 256;
  localparam int PHV_QUEUE_OFF = 141;
  localparam int PHV_QUEUE_W   = 4;

  typedef enum logic [1:0] {
    FIFO_EMPTY  = 2'd0,
    FIFO_ACTIVE = 2'd1,
    FIFO_FULL   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/phv_fifo_mem.sv
// Simple dual-port PHV storage with a registered, read-first output so it maps onto
// block RAM; a read and a write to the same address return the old contents.
module phv_fifo_mem #(
  parameter int W  = 1024,
  parameter int N  = 15,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] r_mem [N];
  logic [W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/phv_egress_fifo.sv
// Egress PHV buffer between the last pipeline stage and the deparser: unstallable push side
// with early-deasserting ready, FWFT head register, saturating drop counter.
module phv_egress_fifo
  import menshen_defs::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_SLACK = 4,
  parameter int CNT_W    = 16
) (
  input  logic                   axis_clk,
  input  logic                   areset,
  input  logic [PHV_LEN-1:0]     phv_in,
  input  logic                   phv_in_valid,
  output logic                   phv_fifo_ready,
  output logic [PHV_LEN-1:0]     phv_out,
  output logic                   phv_out_valid,
  input  logic                   phv_out_ready,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       overflow_cnt
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int MEM_N = DEPTH - 1;
  localparam int AW    = (MEM_N > 1) ? $clog2(MEM_N) : 1;

  localparam logic [OCC_W-1:0] OCC_ONE     = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_RDY_LIM = OCC_W'(DEPTH - AF_SLACK);
  localparam logic [AW-1:0]    PTR_LAST    = AW'(MEM_N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic [OCC_W-1:0]   r_occ;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic               r_src_mem;
  logic [PHV_LEN-1:0] r_bypass;
  logic [CNT_W-1:0]   r_ovf_cnt;
  logic               r_ready;

  fifo_state_e        w_state;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               w_bypass;
  logic               w_wr;
  logic               w_rd;
  logic [OCC_W-1:0]   w_occ_next;
  logic [AW-1:0]      w_wr_ptr_nxt;
  logic [AW-1:0]      w_rd_ptr_nxt;
  logic [PHV_LEN-1:0] w_mem_q;

  // The head always holds the oldest PHV, so storage holds occupancy-1 entries.
  always_comb begin
    w_state = FIFO_ACTIVE;
    if (r_occ == '0)          w_state = FIFO_EMPTY;
    else if (r_occ == OCC_FULL) w_state = FIFO_FULL;

    w_pop    = (w_state != FIFO_EMPTY) & phv_out_ready;
    w_push   = phv_in_valid & ((w_state != FIFO_FULL) | w_pop);
    w_drop   = phv_in_valid & ~w_push;
    w_bypass = w_push & ((w_state == FIFO_EMPTY) | (w_pop & (r_occ == OCC_ONE)));
    w_wr     = w_push & ~w_bypass;
    w_rd     = w_pop & (r_occ > OCC_ONE);

    w_occ_next = r_occ;
    if (w_push & ~w_pop)      w_occ_next = r_occ + OCC_ONE;
    else if (~w_push & w_pop) w_occ_next = r_occ - OCC_ONE;

    w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      r_occ     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_src_mem <= 1'b0;
      r_bypass  <= '0;
      r_ovf_cnt <= '0;
      r_ready   <= 1'b1;
    end else begin
      r_occ   <= w_occ_next;
      r_ready <= (w_occ_next < OCC_RDY_LIM);
      if (w_wr) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd) begin
        r_rd_ptr  <= w_rd_ptr_nxt;
        r_src_mem <= 1'b1;
      end
      if (w_bypass) begin
        r_bypass  <= phv_in;
        r_src_mem <= 1'b0;
      end
      if (w_drop && (r_ovf_cnt != CNT_MAX)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  // The memory read register doubles as the head; it only advances on a refill.
  phv_fifo_mem #(
    .W  (PHV_LEN),
    .N  (MEM_N),
    .AW (AW)
  ) u_mem (
    .clk     (axis_clk),
    .wr_en   (w_wr),
    .wr_addr (r_wr_ptr),
    .wr_data (phv_in),
    .rd_en   (w_rd),
    .rd_addr (r_rd_ptr),
    .rd_data (w_mem_q)
  );

  assign phv_out        = r_src_mem ? w_mem_q : r_bypass;
  assign phv_out_valid  = (w_state != FIFO_EMPTY);
  assign phv_fifo_ready = r_ready;
  assign occupancy      = r_occ;
  assign overflow_cnt   = r_ovf_cnt;

endmodule

// File: tb/tb_phv_egress_fifo.sv
// Directed and randomized checks of phv_egress_fifo against a queue-based reference model.
module tb_phv_egress_fifo;
  import menshen_defs::*;

  localparam int DEPTH    = 16;
  localparam int AF_SLACK = 4;
  localparam int CNT_W    = 16;
  localparam int OCC_W    = $clog2(DEPTH) + 1;
  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  typedef logic [PHV_LEN-1:0] phv_t;

  logic             axis_clk = 1'b0;
  logic             areset = 1'b1;
  phv_t             phv_in = '0;
  logic             phv_in_valid = 1'b0;
  logic             phv_fifo_ready;
  phv_t             phv_out;
  logic             phv_out_valid;
  logic             phv_out_ready = 1'b0;
  logic [OCC_W-1:0] occupancy;
  logic [CNT_W-1:0] overflow_cnt;

  always #5 axis_clk = ~axis_clk;

  phv_egress_fifo #(
    .DEPTH    (DEPTH),
    .AF_SLACK (AF_SLACK),
    .CNT_W    (CNT_W)
  ) dut (
    .axis_clk       (axis_clk),
    .areset         (areset),
    .phv_in         (phv_in),
    .phv_in_valid   (phv_in_valid),
    .phv_fifo_ready (phv_fifo_ready),
    .phv_out        (phv_out),
    .phv_out_valid  (phv_out_valid),
    .phv_out_ready  (phv_out_ready),
    .occupancy      (occupancy),
    .overflow_cnt   (overflow_cnt)
  );

  phv_t        m_q[$];
  int unsigned m_drops = 0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic phv_t rand_phv();
    phv_t p;
    for (int i = 0; i < PHV_LEN / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic check_outputs(input string tag);
    logic exp_valid;
    logic exp_ready;
    exp_valid = (m_q.size() != 0);
    exp_ready = ((DEPTH - m_q.size()) > AF_SLACK);
    n_vec++;
    assert (phv_out_valid === exp_valid) else begin
      n_err++; $error("FAIL %s valid obs=%0b exp=%0b", tag, phv_out_valid, exp_valid);
    end
    n_vec++;
    assert (occupancy === OCC_W'(m_q.size())) else begin
      n_err++; $error("FAIL %s occupancy obs=%0d exp=%0d", tag, occupancy, m_q.size());
    end
    n_vec++;
    assert (phv_fifo_ready === exp_ready) else begin
      n_err++; $error("FAIL %s ready obs=%0b exp=%0b", tag, phv_fifo_ready, exp_ready);
    end
    n_vec++;
    assert (overflow_cnt === CNT_W'(m_drops)) else begin
      n_err++; $error("FAIL %s overflow_cnt obs=%0d exp=%0d", tag, overflow_cnt, m_drops);
    end
    if (exp_valid) begin
      n_vec++;
      assert (phv_out === m_q[0]) else begin
        n_err++; $error("FAIL %s data obs[127:0]=%h exp[127:0]=%h", tag, phv_out[127:0], m_q[0][127:0]);
      end
    end
  endtask

  // Check the state seen this cycle, apply inputs across one clock edge, update the model.
  task automatic cycle(input string tag, input logic v, input phv_t d, input logic r);
    phv_in_valid  = v;
    phv_in        = d;
    phv_out_ready = r;
    check_outputs(tag);
    if (r && m_q.size() != 0) void'(m_q.pop_front());
    if (v) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else if (m_drops < CNT_MAX) m_drops++;
    end
    @(posedge axis_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    areset        = 1'b1;
    phv_in_valid  = 1'b0;
    phv_in        = '0;
    phv_out_ready = 1'b0;
    repeat (n) @(posedge axis_clk);
    #1;
    areset = 1'b0;
    m_q.delete();
    m_drops = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (m_q.size() != 0 && k < budget) begin
      cycle(tag, 1'b0, '0, 1'b1);
      k++;
    end
    n_vec++;
    assert (m_q.size() == 0) else begin
      n_err++; $error("FAIL %s drain budget expired, %0d left", tag, m_q.size());
    end
  endtask

  initial begin
    phv_t a5;
    phv_t x;
    int   pv;
    int   pr;

    // Reset
    do_reset(2);
    check_outputs("reset");
    n_vec++;
    assert (phv_out === '0) else begin
      n_err++; $error("FAIL reset phv_out obs[127:0]=%h exp=0", phv_out[127:0]);
    end

    // Single push, immediate pop
    a5 = {(PHV_LEN/8){8'hA5}};
    cycle("single_push", 1'b1, a5, 1'b1);
    n_vec++;
    assert (phv_out[PHV_QUEUE_OFF +: PHV_QUEUE_W] === a5[PHV_QUEUE_OFF +: PHV_QUEUE_W]) else begin
      n_err++; $error("FAIL single queue_field obs=%h exp=%h",
                      phv_out[PHV_QUEUE_OFF +: PHV_QUEUE_W], a5[PHV_QUEUE_OFF +: PHV_QUEUE_W]);
    end
    cycle("single_pop", 1'b0, '0, 1'b1);
    cycle("single_empty", 1'b0, '0, 1'b1);

    // Fill to full, overflow once, drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      x = rand_phv();
      x[15:0] = 16'(i);
      cycle("fill", 1'b1, x, 1'b0);
    end
    cycle("overflow", 1'b1, rand_phv(), 1'b0);
    cycle("overflow_hold", 1'b0, '0, 1'b0);
    drain("fill_drain", DEPTH + 4);
    cycle("fill_empty", 1'b0, '0, 1'b0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= DEPTH; i++) cycle("refill", 1'b1, rand_phv(), 1'b0);
    x = rand_phv();
    cycle("full_push_pop", 1'b1, x, 1'b1);
    cycle("full_hold", 1'b0, '0, 1'b0);
    drain("full_drain", DEPTH + 4);

    // Streaming at one PHV per clock
    for (int i = 0; i < 40; i++) begin
      cycle("stream", 1'b1, rand_phv(), 1'b1);
      n_vec++;
      assert (occupancy <= OCC_W'(2)) else begin
        n_err++; $error("FAIL stream occupancy obs=%0d exp<=2", occupancy);
      end
    end
    drain("stream_drain", 8);

    // Random traffic, first filling-biased then draining-biased
    for (int i = 0; i < 400; i++) begin
      pv = (i < 200) ? 75 : 50;
      pr = (i < 200) ? 45 : 80;
      cycle("random", ($urandom_range(0, 99) < pv), rand_phv(), ($urandom_range(0, 99) < pr));
    end
    drain("random_drain", DEPTH + 4);

    // Reset in the middle of traffic
    for (int i = 0; i < 7; i++) cycle("pre_reset", 1'b1, rand_phv(), 1'b0);
    check_outputs("pre_reset_occ7");
    do_reset(1);
    check_outputs("mid_reset");
    cycle("post_reset_idle", 1'b0, '0, 1'b0);
    x = rand_phv();
    cycle("post_reset_push", 1'b1, x, 1'b0);
    cycle("post_reset_head", 1'b0, '0, 1'b1);
    cycle("post_reset_empty", 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
